// File: rtl/sga_pkg.sv
// sga_pkg: constants shared by the SGA render path.
//   GRID_ROWS / GRID_COLS : physical LED matrix geometry
//   S_IDLE / S_BLANK / S_DRIVE : scanner state encoding (also exported on db_state)
//   col_off() : column "all off" pattern for a given column polarity
package sga_pkg;

   localparam int unsigned GRID_ROWS = 6;
   localparam int unsigned GRID_COLS = 6;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_BLANK = 2'b01;
   localparam logic [1:0] S_DRIVE = 2'b10;

   // Off level of every column line: all ones when the lines are active-low.
   function automatic logic [31:0] col_off(input int unsigned act_low);
      return (act_low != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
   endfunction

endpackage

// File: rtl/led_matrix_scanner_tick_counter.sv
// tick_counter: loadable down counter with terminal-count flag.
//   clock      in  system clock
//   restart    in  synchronous reset, active-high (count -> 0)
//   load       in  load load_value this cycle (has priority over enable)
//   load_value in  WIDTH-bit value to load
//   enable     in  decrement while non-zero; holds at zero (no wrap)
//   done       out count is zero
module tick_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             restart,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clock) begin
      if (restart) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexed driver for the 6x6 LED matrix.
//   A new framebuffer is captured into a shadow on frame_valid and promoted
//   to the displayed image only at a frame boundary (entry to the row-0
//   blank), so the display never tears. Every row is preceded by a blank
//   interval with all lines off to suppress ghosting.
//   clock        in  system clock
//   restart      in  synchronous reset, active-high
//   enable       in  1 = scan, 0 = dark (IDLE)
//   frame        in  framebuffer, bit r*COLS+c = LED (r, c)
//   frame_valid  in  1-cycle strobe: frame holds a new image
//   frame_taken  out 1-cycle pulse: a new image became the displayed image
//   frame_start  out 1-cycle pulse on entry to the row-0 blank
//   row_sel      out one-hot row drive, active-high
//   col_drive    out column drive, polarity per COL_ACT_LOW
//   db_state     out 00 IDLE, 01 BLANK, 10 DRIVE
//   db_row       out current row index
module led_matrix_scanner
   import sga_pkg::*;
#(
   parameter int unsigned ROWS        = GRID_ROWS,
   parameter int unsigned COLS        = GRID_COLS,
   parameter int unsigned ROW_TICKS   = 50000,
   parameter int unsigned BLANK_TICKS = 500,
   parameter int unsigned COL_ACT_LOW = 1
) (
   input  logic                 clock,
   input  logic                 restart,
   input  logic                 enable,
   input  logic [ROWS*COLS-1:0] frame,
   input  logic                 frame_valid,
   output logic                 frame_taken,
   output logic                 frame_start,
   output logic [ROWS-1:0]      row_sel,
   output logic [COLS-1:0]      col_drive,
   output logic [1:0]           db_state,
   output logic [2:0]           db_row
);

   localparam int unsigned MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
   localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam logic [TW-1:0]   ROW_LOAD   = TW'(ROW_TICKS - 1);
   localparam logic [TW-1:0]   BLANK_LOAD = TW'(BLANK_TICKS - 1);
   localparam logic [COLS-1:0] COL_OFF    = COLS'(col_off(COL_ACT_LOW));
   localparam logic [2:0]      LAST_ROW   = 3'(ROWS - 1);

   if (ROWS == 0 || COLS == 0 || ROW_TICKS == 0 || BLANK_TICKS == 0 ||
       ROWS > 8 || COLS > 32) begin : g_bad_params
      $error("led_matrix_scanner: illegal parameter value");
   end

   logic [1:0]           state;
   logic [2:0]           row;
   logic [ROWS*COLS-1:0] active;
   logic [ROWS*COLS-1:0] shadow;
   logic                 pending;

   logic                 go_idle;
   logic                 enter_blank;
   logic                 enter_drive;
   logic                 boundary;
   logic [2:0]           next_row;
   logic                 cnt_load;
   logic [TW-1:0]        cnt_value;
   logic                 tick_done;
   logic [COLS-1:0]      row_cols;

   tick_counter #(.WIDTH(TW)) u_tick (
      .clock      (clock),
      .restart    (restart),
      .load       (cnt_load),
      .load_value (cnt_value),
      .enable     (state != S_IDLE),
      .done       (tick_done)
   );

   // Each interval reloads the counter with TICKS-1 on entry and leaves on
   // the cycle it reads zero, so an interval lasts exactly TICKS cycles.
   always_comb begin
      go_idle     = 1'b0;
      enter_blank = 1'b0;
      enter_drive = 1'b0;
      next_row    = row;
      if (!enable) begin
         go_idle = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               enter_blank = 1'b1;
               next_row    = '0;
            end
            S_BLANK: begin
               if (tick_done) enter_drive = 1'b1;
            end
            S_DRIVE: begin
               if (tick_done) begin
                  enter_blank = 1'b1;
                  next_row    = (row == LAST_ROW) ? 3'd0 : row + 3'd1;
               end
            end
            default: go_idle = 1'b1;
         endcase
      end
      boundary  = enter_blank && (next_row == 3'd0);
      cnt_load  = go_idle || enter_blank || enter_drive;
      cnt_value = enter_blank ? BLANK_LOAD : (enter_drive ? ROW_LOAD : '0);
   end

   assign row_cols = active[row*COLS +: COLS];

   always_ff @(posedge clock) begin
      if (restart) begin
         state       <= S_IDLE;
         row         <= '0;
         active      <= '0;
         shadow      <= '0;
         pending     <= 1'b0;
         row_sel     <= '0;
         col_drive   <= COL_OFF;
         frame_taken <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_taken <= 1'b0;
         frame_start <= 1'b0;
         if (frame_valid) begin
            shadow  <= frame;
            pending <= 1'b1;
         end
         if (go_idle) begin
            state     <= S_IDLE;
            row       <= '0;
            row_sel   <= '0;
            col_drive <= COL_OFF;
         end else if (enter_blank) begin
            state     <= S_BLANK;
            row       <= next_row;
            row_sel   <= '0;
            col_drive <= COL_OFF;
            if (boundary) begin
               frame_start <= 1'b1;
               // A strobe on the boundary cycle bypasses the shadow so the
               // newest image wins; it also overrides the pending set above.
               if (frame_valid) begin
                  active      <= frame;
                  pending     <= 1'b0;
                  frame_taken <= 1'b1;
               end else if (pending) begin
                  active      <= shadow;
                  pending     <= 1'b0;
                  frame_taken <= 1'b1;
               end
            end
         end else if (enter_drive) begin
            state     <= S_DRIVE;
            row_sel   <= ROWS'(1) << row;
            col_drive <= row_cols ^ COL_OFF;
         end
      end
   end

   assign db_state = state;
   assign db_row   = row;

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;

   localparam int R_T   = 4;
   localparam int B_T   = 2;
   localparam int SLOT  = R_T + B_T;
   localparam int FRAME = 6 * SLOT;

   typedef struct packed {
      logic [5:0] rs;
      logic [5:0] cd;
      logic [1:0] st;
      logic [2:0] rw;
      logic       fs;
      logic       ft;
   } exp_t;

   logic        clk = 1'b0;
   logic        restart = 1'b1;
   logic        enable = 1'b0;
   logic [35:0] frame = '0;
   logic        frame_valid = 1'b0;
   logic        frame_taken;
   logic        frame_start;
   logic [5:0]  row_sel;
   logic [5:0]  col_drive;
   logic [1:0]  db_state;
   logic [2:0]  db_row;

   int tests = 0;
   int fails = 0;

   exp_t exp_q[$];
   exp_t sb_e;
   exp_t m_e;

   // Reference model state: position within the frame (-1 = dark).
   int          m_phase = -1;
   logic [35:0] m_active = '0;
   logic [35:0] m_shadow = '0;
   logic        m_pending = 1'b0;
   logic        m_bnd;
   logic        m_tk;
   int          m_slot;
   int          m_k;

   logic [35:0] pat_b;

   led_matrix_scanner #(
      .ROWS(6), .COLS(6), .ROW_TICKS(R_T), .BLANK_TICKS(B_T), .COL_ACT_LOW(1)
   ) dut (
      .clock       (clk),
      .restart     (restart),
      .enable      (enable),
      .frame       (frame),
      .frame_valid (frame_valid),
      .frame_taken (frame_taken),
      .frame_start (frame_start),
      .row_sel     (row_sel),
      .col_drive   (col_drive),
      .db_state    (db_state),
      .db_row      (db_row)
   );

   always #5 clk = ~clk;

   // Model: predicts the registered outputs produced by each rising edge.
   always @(posedge clk) begin
      m_bnd = 1'b0;
      m_tk  = 1'b0;
      if (restart) begin
         m_phase   = -1;
         m_active  = '0;
         m_shadow  = '0;
         m_pending = 1'b0;
      end else begin
         if (frame_valid) begin
            m_shadow  = frame;
            m_pending = 1'b1;
         end
         if (!enable) begin
            m_phase = -1;
         end else begin
            m_phase = (m_phase < 0) ? 0 : (m_phase + 1) % FRAME;
            m_bnd   = (m_phase == 0);
         end
         if (m_bnd) begin
            if (frame_valid) begin
               m_active  = frame;
               m_pending = 1'b0;
               m_tk      = 1'b1;
            end else if (m_pending) begin
               m_active  = m_shadow;
               m_pending = 1'b0;
               m_tk      = 1'b1;
            end
         end
      end
      m_e.fs = m_bnd;
      m_e.ft = m_tk;
      if (m_phase < 0) begin
         m_e.rs = 6'h00; m_e.cd = 6'h3F; m_e.st = 2'b00; m_e.rw = 3'd0;
      end else begin
         m_slot = m_phase / SLOT;
         m_k    = m_phase % SLOT;
         m_e.rw = 3'(m_slot);
         if (m_k < B_T) begin
            m_e.rs = 6'h00; m_e.cd = 6'h3F; m_e.st = 2'b01;
         end else begin
            m_e.rs = 6'(1 << m_slot);
            m_e.cd = ~m_active[m_slot*6 +: 6];
            m_e.st = 2'b10;
         end
      end
      exp_q.push_back(m_e);
   end

   // Scoreboard: every cycle the DUT output is compared with the prediction.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         sb_e = exp_q.pop_front();
         tests++;
         if ({row_sel, col_drive, db_state, db_row, frame_start, frame_taken} !== sb_e) begin
            fails++;
            $display("FAIL scoreboard t=%0t got rs=%b cd=%b st=%b row=%0d fs=%b ft=%b want rs=%b cd=%b st=%b row=%0d fs=%b ft=%b",
                     $time, row_sel, col_drive, db_state, db_row, frame_start, frame_taken,
                     sb_e.rs, sb_e.cd, sb_e.st, sb_e.rw, sb_e.fs, sb_e.ft);
         end
      end
   end

   task automatic wait_drive_row(input int r, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (db_state == 2'b10 && db_row == 3'(r)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      tests++;
      if (row_sel !== 6'h00 || col_drive !== 6'h3F) begin
         fails++;
         $display("FAIL reset_outputs got rs=%b cd=%b want 000000/111111", row_sel, col_drive);
      end
      tests++;
      if (db_state !== 2'b00 || frame_taken !== 1'b0 || frame_start !== 1'b0) begin
         fails++;
         $display("FAIL reset_state got st=%b ft=%b fs=%b want 00/0/0", db_state, frame_taken, frame_start);
      end
   endtask

   task automatic test_first_frame();
      logic [5:0] ers;
      logic [5:0] ecd;
      frame = 36'h00000003F;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      enable = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c == 0) begin
            tests++;
            if (frame_start !== 1'b1 || frame_taken !== 1'b1) begin
               fails++;
               $display("FAIL first_boundary got fs=%b ft=%b want 1/1", frame_start, frame_taken);
            end
         end
         if (c < 2)      begin ers = 6'h00; ecd = 6'h3F; end
         else if (c < 6) begin ers = 6'h01; ecd = 6'h00; end
         else if (c < 8) begin ers = 6'h00; ecd = 6'h3F; end
         else            begin ers = 6'h02; ecd = 6'h3F; end
         tests++;
         if (row_sel !== ers || col_drive !== ecd) begin
            fails++;
            $display("FAIL first_frame c=%0d got rs=%b cd=%b want rs=%b cd=%b", c, row_sel, col_drive, ers, ecd);
         end
      end
   endtask

   task automatic test_continuous();
      int   cnt;
      bit   seen;
      logic [5:0] last;
      logic [5:0] seq[$];
      logic [5:0] ref_seq[7];
      ref_seq = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (frame_start) begin seen = 1'b1; break; end
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL continuous_first_start got none want pulse within 60 cycles");
      end
      last = 6'h00;
      for (int f = 0; f < 3; f++) begin
         cnt = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (row_sel != 6'h00 && row_sel != last) begin
               seq.push_back(row_sel);
               last = row_sel;
            end
            if (frame_start) break;
         end
         tests++;
         if (cnt != FRAME) begin
            fails++;
            $display("FAIL frame_period f=%0d got %0d want %0d", f, cnt, FRAME);
         end
      end
      for (int i = 0; i < 7; i++) begin
         tests++;
         if (i >= seq.size() || seq[i] !== ref_seq[i]) begin
            fails++;
            $display("FAIL row_order i=%0d got %b want %b", i, (i < seq.size()) ? seq[i] : 6'hxx, ref_seq[i]);
         end
      end
   endtask

   task automatic test_mid_frame_update();
      bit ok;
      bit seen;
      wait_drive_row(2, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL mid_wait_row2 got timeout want row 2 drive"); end
      frame = 36'h000000FC0;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (frame_start) begin seen = 1'b1; break; end
         tests++;
         if (frame_taken !== 1'b0) begin
            fails++;
            $display("FAIL mid_early_take got ft=%b want 0", frame_taken);
         end
         if (row_sel != 6'h00) begin
            tests++;
            if (col_drive !== 6'h3F) begin
               fails++;
               $display("FAIL mid_tearing rs=%b got cd=%b want 111111", row_sel, col_drive);
            end
         end
         @(negedge clk);
      end
      tests++;
      if (!seen || frame_taken !== 1'b1) begin
         fails++;
         $display("FAIL mid_take_at_boundary got seen=%b ft=%b want 1/1", seen, frame_taken);
      end
      wait_drive_row(1, ok);
      tests++;
      if (!ok || col_drive !== 6'h00) begin
         fails++;
         $display("FAIL mid_new_row1 got ok=%b cd=%b want 1/000000", ok, col_drive);
      end
   endtask

   task automatic test_boundary_bypass();
      bit ok;
      int takes;
      pat_b = 36'h00000F0A5;
      wait_drive_row(5, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL bypass_wait_row5 got timeout want row 5 drive"); end
      frame = 36'hFFFFFFFFF;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      frame = pat_b;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      tests++;
      if (frame_start !== 1'b1 || frame_taken !== 1'b1) begin
         fails++;
         $display("FAIL bypass_boundary got fs=%b ft=%b want 1/1", frame_start, frame_taken);
      end
      takes = 0;
      for (int i = 0; i < FRAME - 1; i++) begin
         @(negedge clk);
         if (frame_taken) takes++;
         if (row_sel == 6'h01) begin
            tests++;
            if (col_drive !== ~pat_b[5:0]) begin
               fails++;
               $display("FAIL bypass_row0 got cd=%b want %b", col_drive, ~pat_b[5:0]);
            end
         end
         if (row_sel == 6'h02) begin
            tests++;
            if (col_drive !== ~pat_b[11:6]) begin
               fails++;
               $display("FAIL bypass_row1 got cd=%b want %b", col_drive, ~pat_b[11:6]);
            end
         end
      end
      tests++;
      if (takes != 0) begin
         fails++;
         $display("FAIL bypass_single_take got %0d extra pulses want 0", takes);
      end
   endtask

   task automatic test_enable_drop();
      bit ok;
      wait_drive_row(3, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL drop_wait_row3 got timeout want row 3 drive"); end
      enable = 1'b0;
      @(negedge clk);
      tests++;
      if (db_state !== 2'b00 || row_sel !== 6'h00 || col_drive !== 6'h3F || db_row !== 3'd0) begin
         fails++;
         $display("FAIL drop_dark got st=%b rs=%b cd=%b row=%0d want 00/000000/111111/0",
                  db_state, row_sel, col_drive, db_row);
      end
      repeat (3) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      tests++;
      if (db_state !== 2'b01 || frame_start !== 1'b1 || frame_taken !== 1'b0 || db_row !== 3'd0) begin
         fails++;
         $display("FAIL drop_resume got st=%b fs=%b ft=%b row=%0d want 01/1/0/0",
                  db_state, frame_start, frame_taken, db_row);
      end
      wait_drive_row(0, ok);
      tests++;
      if (!ok || col_drive !== ~pat_b[5:0]) begin
         fails++;
         $display("FAIL drop_same_image got ok=%b cd=%b want 1/%b", ok, col_drive, ~pat_b[5:0]);
      end
   endtask

   task automatic test_restart_mid();
      bit ok;
      int drives;
      wait_drive_row(2, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL restart_wait_row2 got timeout want row 2 drive"); end
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      tests++;
      if (db_state !== 2'b00 || row_sel !== 6'h00) begin
         fails++;
         $display("FAIL restart_mid got st=%b rs=%b want 00/000000", db_state, row_sel);
      end
      drives = 0;
      for (int i = 0; i < FRAME + 4; i++) begin
         @(negedge clk);
         if (row_sel != 6'h00) begin
            drives++;
            tests++;
            if (col_drive !== 6'h3F) begin
               fails++;
               $display("FAIL restart_cleared rs=%b got cd=%b want 111111", row_sel, col_drive);
            end
         end
      end
      tests++;
      if (drives == 0) begin
         fails++;
         $display("FAIL restart_rescan got 0 drive cycles want >0");
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_continuous();
      test_mid_frame_update();
      test_boundary_bypass();
      test_enable_drop();
      test_restart_mid();
      enable = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
